syscall_string_reader: RTL and testbench

SYSCALL_STRING_READER -- requirements
Module: syscall_string_reader

---
 rtl/mips_pkg.sv | 31 +++
 rtl/toggle_char_rx.sv | 32 +++
 rtl/syscall_string_reader.sv | 211 +++++++++++++++++++++
 tb/tb_syscall_string_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the syscall string reader.
// Holds FSM states, character constants and data-segment bounds.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam logic [7:0] NEWLINE = 8'd10;
  localparam logic [7:0] NUL     = 8'd0;

  localparam logic [31:0] DATA_BEGIN_DEF = 32'h0040_0000;
  localparam logic [31:0] DATA_END_DEF   = 32'h0041_0f00;

  typedef struct packed {
    logic       tog;
    logic [7:0] ch;
  } tchar_t;

  function automatic logic addr_ok(
    input logic [31:0] addr,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/toggle_char_rx.sv
// Toggle-coded character receiver: a new character is signalled
// by char_i.tog differing from the last reference toggle.
module toggle_char_rx
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       capture_i,
  input  logic       enable_i,
  input  tchar_t     char_i,
  output logic       char_valid_o,
  output logic [7:0] char_data_o
);

  logic ref_q;
  logic ref_d;

  assign char_valid_o = enable_i && (char_i.tog != ref_q);
  assign char_data_o  = char_i.ch;

  // Start re-arms the reference so a pending stale toggle is skipped.
  always_comb begin
    ref_d = ref_q;
    if (capture_i || char_valid_o) ref_d = char_i.tog;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ref_q <= 1'b0;
    else       ref_q <= ref_d;
  end

endmodule

// File: rtl/syscall_string_reader.sv
// read_string syscall engine: packs toggle-coded chars into words.
// Optional echo output enabled by SYSCALL_READ_ECHO_EN.
module syscall_string_reader
  import mips_pkg::*;
#(
  parameter logic [31:0] DATA_BEGIN = DATA_BEGIN_DEF,
  parameter logic [31:0] DATA_END   = DATA_END_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] buf_addr,
  input  logic [31:0] max_len,
  input  logic [8:0]  char_in,
  output logic        mem_write,
  output logic [31:0] a,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] count,
  output logic        err,
  output logic [8:0]  echo_char
);

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] max_q, max_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [29:0] widx_q, widx_d;
  logic        wr_q, wr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;

  tchar_t      ch_in;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        capture;
  logic [1:0]  lane;
  logic [31:0] waddr;
  logic [31:0] filled;
  logic [31:0] cnt_inc;

  assign ch_in = char_in;

  toggle_char_rx u_rx (
    .clk          (clk),
    .reset        (reset),
    .capture_i    (capture),
    .enable_i     (state_q == S_COLLECT),
    .char_i       (ch_in),
    .char_valid_o (rx_valid),
    .char_data_o  (rx_data)
  );

  assign lane    = cnt_q[1:0];
  assign waddr   = base_q + {widx_q, 2'b00};
  assign filled  = word_q | ({24'h0, rx_data} << {lane, 3'b000});
  assign cnt_inc = cnt_q + 32'd1;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    widx_d  = widx_q;
    wr_d    = 1'b0;
    a_d     = a_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    err_d   = err_q;
    abort_d = abort_q;
    busy_d  = busy_q;
    capture = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          abort_d = 1'b0;
          cnt_d   = '0;
          word_d  = {4{NUL}};
          widx_d  = '0;
          base_d  = buf_addr;
          max_d   = max_len;
          if (!addr_ok(buf_addr, DATA_BEGIN, DATA_END)) begin
            abort_d = 1'b1;
            state_d = S_DONE;
          end else if (max_len == 32'd0) begin
            state_d = S_DONE;
          end else if (max_len == 32'd1) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        if (rx_valid) begin
          cnt_d = cnt_inc;
          if (lane == 2'd3) begin
            // Full word: issue it and restart packing at lane 0.
            if (waddr > DATA_END) begin
              abort_d = 1'b1;
              state_d = S_DONE;
            end else begin
              wr_d   = 1'b1;
              a_d    = waddr;
              wd_d   = filled;
              word_d = {4{NUL}};
              widx_d = widx_q + 30'd1;
            end
          end else begin
            word_d = filled;
          end
          if (state_d != S_DONE &&
              (rx_data == NEWLINE || cnt_inc == max_q - 32'd1))
            state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        // Unused lanes are already NUL, so word_q is the final word.
        state_d = S_DONE;
        if (waddr > DATA_END) begin
          abort_d = 1'b1;
        end else begin
          wr_d = 1'b1;
          a_d  = waddr;
          wd_d = word_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = abort_q;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      widx_q  <= '0;
      wr_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      widx_q  <= widx_d;
      wr_q    <= wr_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_write  = wr_q;
  assign a          = a_q;
  assign write_data = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign count      = cnt_q;
  assign err        = err_q;

`ifdef SYSCALL_READ_ECHO_EN
  logic [8:0] echo_q, echo_d;

  always_comb begin
    echo_d = echo_q;
    if (rx_valid) echo_d = {~echo_q[8], rx_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) echo_q <= 9'h0;
    else       echo_q <= echo_d;
  end

  assign echo_char = echo_q;
`else
  assign echo_char = 9'h0;
`endif

endmodule

// File: tb/tb_syscall_string_reader.sv
// Randomized self-checking bench for syscall_string_reader.
// Expected writes come from a string-level reference model.
module tb_syscall_string_reader;

  localparam logic [31:0] DB = 32'h0040_0000;
  localparam logic [31:0] DE = 32'h0041_0f00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] buf_addr = '0;
  logic [31:0] max_len = '0;
  logic [8:0]  char_in = '0;
  logic        mem_write;
  logic [31:0] a;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] count;
  logic        err;
  logic [8:0]  echo_char;

  int n_checks = 0;
  int n_errors = 0;

  logic        tog = 1'b0;
  logic [63:0] wq[$];
  logic        done_seen = 1'b0;
  logic [31:0] cnt_at = '0;
  logic        err_at = 1'b0;
  logic        wr_at = 1'b0;

  always #5 clk = ~clk;

  syscall_string_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .buf_addr   (buf_addr),
    .max_len    (max_len),
    .char_in    (char_in),
    .mem_write  (mem_write),
    .a          (a),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .err        (err),
    .echo_char  (echo_char)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_write) wq.push_back({a, write_data});
    if (done) begin
      done_seen = 1'b1;
      cnt_at = count;
      err_at = err;
      wr_at = mem_write;
    end
  end

  task automatic do_start(input logic [31:0] ad, input logic [31:0] ml);
    @(posedge clk); #1;
    wq.delete();
    done_seen = 1'b0;
    start = 1'b1;
    buf_addr = ad;
    max_len = ml;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'h0, busy}, 32'd1);
  endtask

  task automatic send_chars(input string s, input int gap);
    int g;
    for (int i = 0; i < s.len(); i++) begin
      if (done_seen) break;
      tog = ~tog;
      char_in = {tog, s[i]};
      g = (gap == 0) ? int'($urandom_range(3, 1)) : gap;
      repeat (g) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_txn(input string name, input logic [31:0] ad,
                         input logic [31:0] ml, input string s,
                         input int gap);
    logic        bad;
    logic        e_err;
    int          n;
    int          budget;
    logic [7:0]  bq[$];
    logic [31:0] ea[$];
    logic [31:0] ew[$];
    logic [31:0] w;

    bad = (ad[1:0] != 2'b00) || (ad < DB) || (ad > DE);
    e_err = bad;
    n = 0;
    if (!bad && ml != 0) begin
      for (int i = 0; i < s.len(); i++) begin
        if (longint'(n) == longint'(ml) - 1) break;
        bq.push_back(s[i]);
        n++;
        if (s[i] == 8'd10) break;
      end
      bq.push_back(8'd0);
      while (bq.size() % 4 != 0) bq.push_back(8'd0);
      for (int k = 0; k < bq.size() / 4; k++) begin
        if (ad + 32'(4 * k) > DE) begin
          e_err = 1'b1;
          break;
        end
        w = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
        ea.push_back(ad + 32'(4 * k));
        ew.push_back(w);
      end
    end

    if ($urandom_range(1, 0) == 1) begin
      tog = ~tog;
      char_in = {tog, 8'h5a};
    end
    do_start(ad, ml);
    send_chars(s, gap);
    budget = 60;
    while (!done_seen && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check({name, ":done_seen"}, {31'h0, done_seen}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({name, ":err"}, {31'h0, err_at}, {31'h0, e_err});
    check({name, ":wr_with_done"}, {31'h0, wr_at}, 32'd0);
    if (!e_err || bad) check({name, ":count"}, cnt_at, 32'(n));
    check({name, ":nwrites"}, wq.size(), ew.size());
    for (int k = 0; k < ew.size(); k++) begin
      if (k < wq.size()) begin
        check({name, ":waddr"}, wq[k][63:32], ea[k]);
        check({name, ":wdata"}, wq[k][31:0], ew[k]);
      end
    end
`ifndef SYSCALL_READ_ECHO_EN
    check({name, ":echo_off"}, {23'h0, echo_char}, 32'd0);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":mem_write"}, {31'h0, mem_write}, 32'd0);
    check({tag, ":busy"}, {31'h0, busy}, 32'd0);
    check({tag, ":done"}, {31'h0, done}, 32'd0);
    check({tag, ":err"}, {31'h0, err}, 32'd0);
    check({tag, ":a"}, a, 32'd0);
    check({tag, ":wdata"}, write_data, 32'd0);
    check({tag, ":count"}, count, 32'd0);
    check({tag, ":echo"}, {23'h0, echo_char}, 32'd0);
  endtask

  function automatic string rand_str();
    string s;
    int    len;
    s = "";
    len = $urandom_range(10, 0);
    for (int i = 0; i < len; i++)
      s = {s, string'(8'($urandom_range(122, 97)))};
    s = {s, "\n"};
    if ($urandom_range(1, 0) == 1) s = {s, "zz"};
    return s;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(9, 0))
      0: return DB + 32'(4 * $urandom_range(100, 0)) + 32'($urandom_range(3, 1));
      1: return DB - 32'(4 * $urandom_range(4, 1));
      2: return DE + 32'(4 * $urandom_range(4, 1));
      3, 4: return DE - 32'(4 * $urandom_range(3, 0));
      default: return DB + 32'(4 * $urandom_range(1000, 0));
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    run_txn("hi", 32'h0040_0100, 32'd16, "hi\n", 0);
    run_txn("cap5", 32'h0040_0200, 32'd5, "abcdefg", 0);
    run_txn("same_cycle", 32'h0040_0300, 32'd16, "abcde\n", 1);
    run_txn("misalign", 32'h0040_0102, 32'd16, "ab\n", 0);
    run_txn("len0", 32'h0040_0100, 32'd0, "ab\n", 0);
    run_txn("len1", 32'h0040_0400, 32'd1, "ab\n", 0);
    run_txn("full_nul", 32'h0040_0500, 32'd16, "abc\n", 1);
    run_txn("end_ok", DE, 32'd1, "a\n", 0);
    run_txn("end_ovf", DE, 32'd16, "abcd\n", 0);
    run_txn("below", DB - 32'd4, 32'd8, "a\n", 0);

    do_start(32'h0040_0100, 32'd16);
    send_chars("ab", 1);
    #3 reset = 1'b1;
    #1 check_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("mid_reset:nwrites", wq.size(), 32'd0);
    run_txn("after_reset", 32'h0040_0100, 32'd16, "x\n", 0);

    for (int t = 0; t < 40; t++)
      run_txn("rand", rand_addr(), 32'($urandom_range(14, 0)),
              rand_str(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
